win_tail_vote_session: RTL and testbench
========================================

# win_tail_vote_session

Sequential, parametrised successor to the team's fixed 4-input win/tie/lose voter. It runs a timed voting session over `N_VOTERS` independent ballot inputs and latches each voter's first vote per round. On a tie it re-runs rounds up to a limit, then emits a held one-hot verdict. It sits between the voter front-end (buttons or remote links) and the result display/logging logic.

## Interface
- `N_VOTERS`, 4, number of voters (≥2).
- `TIMEOUT_CYCLES`, 16, maximum cycles a round stays open (≥1).
- `MAX_ROUNDS`, 3, total rounds allowed, including the first (≥1).
- `CHAIR_BREAK`, 1, if 1 a final-round tie is resolved by `chair_yes`; if 0 the final verdict is tie.

Ports:
- `clk`  in  1  single clock; everything is on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  opens a session; ignored while `busy`=1.
- `vote_valid`  in  N_VOTERS  per-voter ballot strobe.
- `vote_yes`  in  N_VOTERS  per-voter ballot value, qualified by `vote_valid`.
- `chair_yes`  in  1  tie-break value, sampled only in TALLY of the final round.
- `busy`  out  1  high from COLLECT through TALLY.
- `done`  out  1  one-cycle pulse when the verdict is updated.
- `verdict`  out  3  one-hot {lose, tie, win} in bits [2], [1], [0]; held until the next `done` or reset.
- `yes_count`  out  $clog2(N_VOTERS+1)  yes tally of the last tallied round.
- `round_num`  out  $clog2(MAX_ROUNDS+1)  current or last round, 1-based; 0 in IDLE after reset.
- `tie_retry`  out  1  one-cycle pulse when a tied round restarts.

## Operation
- The FSM has four states: IDLE, COLLECT, TALLY, RESULT.
- IDLE→COLLECT on `start`. On entry: `round_num`=1, ballot mask cleared, timeout counter cleared.
- COLLECT:
  - For each voter i with `vote_valid[i]`=1 and mask[i]=0: set mask[i] and latch `vote_yes[i]`.
  - Later strobes from the same voter in the same round are ignored.
  - Leave for TALLY when the mask is all ones, or when the timeout counter reaches `TIMEOUT_CYCLES`-1.
  - Votes sampled on that final COLLECT cycle are counted.
  - Missing ballots count as no.
- TALLY (one cycle): y = popcount of latched yes bits.
  - Win if 2y>N.
  - Lose if 2y<N.
  - Tie if 2y=N, which is only possible for even N.
  - For N=4 this gives exactly the legacy mapping: 0–1 yes = lose, 2 = tie, 3–4 = win.
- Tie with `round_num`<`MAX_ROUNDS`: pulse `tie_retry`, increment `round_num`, clear mask and timeout counter, return to COLLECT. `verdict` is not changed.
- Tie in the final round:
  - `CHAIR_BREAK`=1: verdict = win if `chair_yes`=1, else lose.
  - `CHAIR_BREAK`=0: verdict = tie.
- Non-tie, or the final round resolved: go to RESULT.
- RESULT (one cycle): pulse `done`, drive `verdict` and `yes_count` from registers, return to IDLE.
- Arithmetic: popcount and compare are unsigned, with 2y computed at $clog2(N_VOTERS+1)+1 bits so nothing overflows.

## Timing
- Reset values: FSM=IDLE, `busy`=0, `done`=0, `tie_retry`=0, `verdict`=3'b000, `yes_count`=0, `round_num`=0, mask and yes registers=0.
- Reset asserted mid-session aborts it on the next edge. No `done` is emitted and `verdict` returns to 3'b000.
- `start` at edge t puts the FSM in COLLECT at t+1, with `busy`=1 from t+1.
- If the last ballot is latched at edge k, TALLY occupies cycle k+1.
- RESULT occupies cycle k+2: `done`=1 and the new `verdict` is visible during that cycle.
- With no votes at all, TALLY comes `TIMEOUT_CYCLES` cycles after COLLECT entry.
- `tie_retry` is high during TALLY, and COLLECT resumes on the next cycle.
- `start` arriving together with `done` (the RESULT cycle) is ignored. `start` in IDLE on the following cycle is accepted.
- All votes arriving in one cycle are latched together and end COLLECT on that edge.

## Structure
- Package `win_tail_pkg` holds:
  - the state enum;
  - verdict bit-position constants `WIN_BIT`=0, `TIE_BIT`=1, `LOSE_BIT`=2;
  - the one-hot verdict constants.
- Sub-module `win_tail_classify`: combinational popcount plus the win/tie/lose compare, parametrised by `N_VOTERS`. It is reusable by any fixed-voter front-end.
- The top level owns the FSM, the counters and the ballot registers.

## Test plan
All scenarios use the default parameters (N=4, TIMEOUT=16, MAX_ROUNDS=3, CHAIR_BREAK=1).
- Votes 1,1,1,0 all in cycle 2 after `start` → `done` in cycle 4, `verdict`=3'b001, `yes_count`=3, `round_num`=1.
- Voter 0 votes yes at cycle 2, then no at cycle 3; no other votes → only the first ballot counts. Timeout after 16 cycles, `verdict`=3'b100, `yes_count`=1.
- Votes 1,1,0,0 in every round with `chair_yes`=1 → `tie_retry` pulses twice, `round_num` ends at 3, `verdict`=3'b001, `yes_count`=2.
- Same as the previous scenario with `CHAIR_BREAK`=0 → `verdict`=3'b010 after round 3.
- Pull `rst_n` low during COLLECT of round 2 → next cycle: IDLE, `verdict`=0, `round_num`=0, and no `done` pulse.
- Assert `start` during COLLECT and on the `done` cycle → both ignored. A `start` in the following IDLE cycle begins a new session with `round_num`=1.

Source files
------------

// File: rtl/win_tail_pkg.sv
// Shared types and constants for the win/tie/lose voting session.
package win_tail_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_TALLY   = 2'd2,
      ST_RESULT  = 2'd3
   } state_e;

   localparam int WIN_BIT  = 0;
   localparam int TIE_BIT  = 1;
   localparam int LOSE_BIT = 2;

   localparam logic [2:0] VERDICT_NONE = 3'b000;
   localparam logic [2:0] VERDICT_WIN  = 3'b001;
   localparam logic [2:0] VERDICT_TIE  = 3'b010;
   localparam logic [2:0] VERDICT_LOSE = 3'b100;

endpackage

// File: rtl/win_tail_classify.sv
// Combinational popcount of yes ballots and win/tie/lose majority compare.
module win_tail_classify #(
   parameter int N_VOTERS = 4
) (
   input  logic [N_VOTERS-1:0]              yes,
   output logic [$clog2(N_VOTERS+1)-1:0]    yes_cnt,
   output logic                             win,
   output logic                             tie,
   output logic                             lose
);
   localparam int CW = $clog2(N_VOTERS + 1);

   logic [CW:0] two_y_s;
   logic [CW:0] n_s;

   // Popcount, then compare 2y against N with one spare bit so nothing wraps.
   always_comb begin
      yes_cnt = '0;
      for (int i = 0; i < N_VOTERS; i++) begin
         yes_cnt = yes_cnt + CW'(yes[i]);
      end
      two_y_s = {yes_cnt, 1'b0};
      n_s     = (CW + 1)'(N_VOTERS);
      win     = (two_y_s > n_s);
      tie     = (two_y_s == n_s);
      lose    = (two_y_s < n_s);
   end

endmodule

// File: rtl/win_tail_vote_session.sv
// Timed multi-round voting session: latches first ballots, retries ties, holds a one-hot verdict.
module win_tail_vote_session
   import win_tail_pkg::*;
#(
   parameter int N_VOTERS       = 4,
   parameter int TIMEOUT_CYCLES = 16,
   parameter int MAX_ROUNDS     = 3,
   parameter int CHAIR_BREAK    = 1
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              start,
   input  logic [N_VOTERS-1:0]               vote_valid,
   input  logic [N_VOTERS-1:0]               vote_yes,
   input  logic                              chair_yes,
   output logic                              busy,
   output logic                              done,
   output logic [2:0]                        verdict,
   output logic [$clog2(N_VOTERS+1)-1:0]     yes_count,
   output logic [$clog2(MAX_ROUNDS+1)-1:0]   round_num,
   output logic                              tie_retry
);
   localparam int CW = $clog2(N_VOTERS + 1);
   localparam int RW = $clog2(MAX_ROUNDS + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   state_e              state_r, state_nxt_s;
   logic [N_VOTERS-1:0] mask_r, yes_r;
   logic [N_VOTERS-1:0] mask_nxt_s, yes_nxt_s;
   logic [TW-1:0]       tmo_r;
   logic [RW-1:0]       round_r;
   logic [2:0]          verdict_r, resolved_s;
   logic [CW-1:0]       ycnt_r, cls_y_r, y_s;
   logic                cls_win_r, cls_tie_r, cls_lose_r;
   logic                win_s, tie_s, lose_s;
   logic                done_r, busy_r, tie_retry_r;
   logic                collect_end_s, final_round_s;

   // Classification is taken on the ballots as they will stand after this edge,
   // so the result is registered on the way into TALLY.
   assign mask_nxt_s = mask_r | vote_valid;
   assign yes_nxt_s  = yes_r | (vote_valid & ~mask_r & vote_yes);

   win_tail_classify #(.N_VOTERS(N_VOTERS)) u_classify (
      .yes     (yes_nxt_s),
      .yes_cnt (y_s),
      .win     (win_s),
      .tie     (tie_s),
      .lose    (lose_s)
   );

   assign collect_end_s = (&mask_nxt_s) || (tmo_r == TW'(TIMEOUT_CYCLES - 1));
   assign final_round_s = (round_r >= RW'(MAX_ROUNDS));

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) state_nxt_s = ST_COLLECT;
            else       state_nxt_s = ST_IDLE;
         end
         ST_COLLECT: begin
            if (collect_end_s) state_nxt_s = ST_TALLY;
            else               state_nxt_s = ST_COLLECT;
         end
         ST_TALLY: begin
            if (cls_tie_r && !final_round_s) state_nxt_s = ST_COLLECT;
            else                             state_nxt_s = ST_RESULT;
         end
         ST_RESULT: state_nxt_s = ST_IDLE;
         default:   state_nxt_s = ST_IDLE;
      endcase
   end

   // Verdict for a resolved round; a final-round tie goes to the chair when enabled.
   always_comb begin
      resolved_s = VERDICT_NONE;
      if (cls_win_r) begin
         resolved_s = VERDICT_WIN;
      end else if (cls_lose_r) begin
         resolved_s = VERDICT_LOSE;
      end else if (CHAIR_BREAK != 0) begin
         resolved_s = chair_yes ? VERDICT_WIN : VERDICT_LOSE;
      end else begin
         resolved_s = VERDICT_TIE;
      end
   end

   // State, ballot, counter and output registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         mask_r      <= '0;
         yes_r       <= '0;
         tmo_r       <= '0;
         round_r     <= '0;
         verdict_r   <= VERDICT_NONE;
         ycnt_r      <= '0;
         cls_y_r     <= '0;
         cls_win_r   <= 1'b0;
         cls_tie_r   <= 1'b0;
         cls_lose_r  <= 1'b0;
         done_r      <= 1'b0;
         busy_r      <= 1'b0;
         tie_retry_r <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         done_r      <= 1'b0;
         tie_retry_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  round_r <= RW'(1);
                  mask_r  <= '0;
                  yes_r   <= '0;
                  tmo_r   <= '0;
                  busy_r  <= 1'b1;
               end
            end
            ST_COLLECT: begin
               mask_r <= mask_nxt_s;
               yes_r  <= yes_nxt_s;
               tmo_r  <= tmo_r + TW'(1);
               if (collect_end_s) begin
                  cls_y_r     <= y_s;
                  cls_win_r   <= win_s;
                  cls_tie_r   <= tie_s;
                  cls_lose_r  <= lose_s;
                  tie_retry_r <= tie_s && !final_round_s;
               end
            end
            ST_TALLY: begin
               if (cls_tie_r && !final_round_s) begin
                  round_r <= round_r + RW'(1);
                  mask_r  <= '0;
                  yes_r   <= '0;
                  tmo_r   <= '0;
               end else begin
                  verdict_r <= resolved_s;
                  ycnt_r    <= cls_y_r;
                  done_r    <= 1'b1;
                  busy_r    <= 1'b0;
               end
            end
            ST_RESULT: begin
               busy_r <= 1'b0;
            end
            default: begin
               busy_r <= 1'b0;
            end
         endcase
      end
   end

   assign busy      = busy_r;
   assign done      = done_r;
   assign verdict   = verdict_r;
   assign yes_count = ycnt_r;
   assign round_num = round_r;
   assign tie_retry = tie_retry_r;

endmodule

// File: tb/tb_win_tail_vote_session.sv
// Directed bench: two instances (chair break on/off) driven in lockstep, sampled on falling edges.
module tb_win_tail_vote_session;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [3:0] vote_valid;
   logic [3:0] vote_yes;
   logic       chair_yes;

   logic       busy_a, done_a, tie_retry_a;
   logic [2:0] verdict_a, yes_count_a;
   logic [1:0] round_num_a;
   logic       busy_b, done_b, tie_retry_b;
   logic [2:0] verdict_b, yes_count_b;
   logic [1:0] round_num_b;

   int n_checks = 0;
   int n_errors = 0;

   win_tail_vote_session #(.N_VOTERS(4), .TIMEOUT_CYCLES(16), .MAX_ROUNDS(3), .CHAIR_BREAK(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start), .vote_valid(vote_valid), .vote_yes(vote_yes),
      .chair_yes(chair_yes), .busy(busy_a), .done(done_a), .verdict(verdict_a),
      .yes_count(yes_count_a), .round_num(round_num_a), .tie_retry(tie_retry_a)
   );

   win_tail_vote_session #(.N_VOTERS(4), .TIMEOUT_CYCLES(16), .MAX_ROUNDS(3), .CHAIR_BREAK(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start), .vote_valid(vote_valid), .vote_yes(vote_yes),
      .chair_yes(chair_yes), .busy(busy_b), .done(done_b), .verdict(verdict_b),
      .yes_count(yes_count_b), .round_num(round_num_b), .tie_retry(tie_retry_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic set_votes(input logic [3:0] v, input logic [3:0] y);
      vote_valid = v;
      vote_yes   = y;
   endtask

   // Waits on falling edges until dut_a pulses done; n is the number of edges waited.
   task automatic wait_done(input int budget, output int n);
      n = 0;
      while (!done_a && n < budget) begin
         step();
         n++;
      end
      if (!done_a) begin
         n_checks++;
         n_errors++;
         $display("FAIL wait_done: got timeout expected done within %0d cycles", budget);
      end
   endtask

   int n;

   initial begin
      rst_n = 1'b0; start = 1'b0; chair_yes = 1'b0;
      set_votes(4'b0000, 4'b0000);
      step(); step();
      check_eq("rst_busy",      32'(busy_a),      32'd0);
      check_eq("rst_done",      32'(done_a),      32'd0);
      check_eq("rst_verdict",   32'(verdict_a),   32'd0);
      check_eq("rst_yes_count", 32'(yes_count_a), 32'd0);
      check_eq("rst_round",     32'(round_num_a), 32'd0);
      check_eq("rst_tie_retry", 32'(tie_retry_a), 32'd0);
      rst_n = 1'b1;
      step();

      // Scenario 1: votes 1,1,1,0 together on the first COLLECT cycle.
      start = 1'b1;
      step();
      start = 1'b0;
      check_eq("s1_busy_collect", 32'(busy_a),      32'd1);
      check_eq("s1_round_collect",32'(round_num_a), 32'd1);
      set_votes(4'b1111, 4'b0111);
      step();
      set_votes(4'b0000, 4'b0000);
      check_eq("s1_tally_done",   32'(done_a),      32'd0);
      check_eq("s1_tally_busy",   32'(busy_a),      32'd1);
      check_eq("s1_tally_retry",  32'(tie_retry_a), 32'd0);
      step();
      check_eq("s1_done",         32'(done_a),      32'd1);
      check_eq("s1_verdict",      32'(verdict_a),   32'b001);
      check_eq("s1_yes_count",    32'(yes_count_a), 32'd3);
      check_eq("s1_round",        32'(round_num_a), 32'd1);
      check_eq("s1_busy_result",  32'(busy_a),      32'd0);
      check_eq("s1_verdict_b",    32'(verdict_b),   32'b001);
      step();
      check_eq("s1_done_pulse",   32'(done_a),      32'd0);
      check_eq("s1_verdict_hold", 32'(verdict_a),   32'b001);

      // Scenario 2: voter 0 yes then no; only the first ballot counts, timeout ends the round.
      start = 1'b1;
      step();
      start = 1'b0;
      set_votes(4'b0001, 4'b0001);
      step();
      set_votes(4'b0001, 4'b0000);
      step();
      set_votes(4'b0000, 4'b0000);
      wait_done(40, n);
      check_eq("s2_latency",   32'(n),           32'd15);
      check_eq("s2_verdict",   32'(verdict_a),   32'b100);
      check_eq("s2_yes_count", 32'(yes_count_a), 32'd1);

      // Scenario 3/4: 1,1,0,0 every round; chair breaks the final tie on dut_a, dut_b reports tie.
      step();
      chair_yes = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      set_votes(4'b1111, 4'b0011);
      step();
      set_votes(4'b0000, 4'b0000);
      check_eq("s3_retry1",       32'(tie_retry_a), 32'd1);
      check_eq("s3_retry1_round", 32'(round_num_a), 32'd1);
      step();
      check_eq("s3_retry1_pulse", 32'(tie_retry_a), 32'd0);
      check_eq("s3_round2",       32'(round_num_a), 32'd2);
      check_eq("s3_busy_r2",      32'(busy_a),      32'd1);
      set_votes(4'b1111, 4'b0011);
      step();
      set_votes(4'b0000, 4'b0000);
      check_eq("s3_retry2",       32'(tie_retry_a), 32'd1);
      step();
      check_eq("s3_round3",       32'(round_num_a), 32'd3);
      check_eq("s3_no_done_yet",  32'(done_a),      32'd0);
      set_votes(4'b1111, 4'b0011);
      step();
      set_votes(4'b0000, 4'b0000);
      check_eq("s3_final_retry",  32'(tie_retry_a), 32'd0);
      step();
      check_eq("s3_done",         32'(done_a),      32'd1);
      check_eq("s3_verdict",      32'(verdict_a),   32'b001);
      check_eq("s3_yes_count",    32'(yes_count_a), 32'd2);
      check_eq("s3_round_end",    32'(round_num_a), 32'd3);
      check_eq("s4_done_b",       32'(done_b),      32'd1);
      check_eq("s4_verdict_b",    32'(verdict_b),   32'b010);
      check_eq("s4_yes_count_b",  32'(yes_count_b), 32'd2);
      chair_yes = 1'b0;
      step();

      // Scenario 5: reset during COLLECT of round 2 aborts the session.
      start = 1'b1;
      step();
      start = 1'b0;
      set_votes(4'b1111, 4'b0011);
      step();
      set_votes(4'b0000, 4'b0000);
      step();
      check_eq("s5_round2",       32'(round_num_a), 32'd2);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check_eq("s5_rst_round",    32'(round_num_a), 32'd0);
      check_eq("s5_rst_verdict",  32'(verdict_a),   32'd0);
      check_eq("s5_rst_busy",     32'(busy_a),      32'd0);
      check_eq("s5_rst_done",     32'(done_a),      32'd0);
      step(); step();
      check_eq("s5_no_done",      32'(done_a),      32'd0);

      // Scenario 6: start during COLLECT and on the done cycle is ignored.
      start = 1'b1;
      step();
      set_votes(4'b1111, 4'b0000);
      step();
      start = 1'b0;
      set_votes(4'b0000, 4'b0000);
      check_eq("s6_tally_round",  32'(round_num_a), 32'd1);
      step();
      check_eq("s6_done",         32'(done_a),      32'd1);
      check_eq("s6_verdict",      32'(verdict_a),   32'b100);
      check_eq("s6_yes_count",    32'(yes_count_a), 32'd0);
      start = 1'b1;
      step();
      check_eq("s6_idle_busy",    32'(busy_a),      32'd0);
      check_eq("s6_idle_done",    32'(done_a),      32'd0);
      step();
      start = 1'b0;
      check_eq("s6_new_busy",     32'(busy_a),      32'd1);
      check_eq("s6_new_round",    32'(round_num_a), 32'd1);
      // Ballots split across cycles: two now, two later, 3 yes overall.
      set_votes(4'b0011, 4'b0011);
      step();
      set_votes(4'b0000, 4'b0000);
      step();
      set_votes(4'b1100, 4'b0100);
      step();
      set_votes(4'b0000, 4'b0000);
      step();
      check_eq("s6_split_done",   32'(done_a),      32'd1);
      check_eq("s6_split_verdict",32'(verdict_a),   32'b001);
      check_eq("s6_split_yes",    32'(yes_count_a), 32'd3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
